// File: rtl/control_flow_commit_pkg.sv
// -----------------------------------------------------------------------------
// control_flow_commit_pkg
// Shared definitions for the branch commit queue: address/index widths, queue
// depth, bit positions inside the controlFlow commit word, the queue-entry
// record and the mispredict rule applied to a resolved entry.
// -----------------------------------------------------------------------------
package control_flow_commit_pkg;

    localparam int WIDTH = 31;                 // address MSB
    localparam int INDEX = 7;                  // GHR index MSB
    localparam int DEPTH = 8;                  // queue entries, power of two
    localparam int PTR_W = $clog2(DEPTH);      // head/tail/tag width

    // Bit positions of the controlFlow word handed to instruction fetch
    localparam int CF_MISPREDICT = 0;
    localparam int CF_TAKEN      = 1;
    localparam int CF_BTB_WRITE  = 2;
    localparam int CF_PHT_LSB    = 3;
    localparam int CF_PHT_MSB    = 4;

    // One in-flight branch/JAL tracked from fetch to retirement
    typedef struct packed {
        logic [WIDTH:0] pc;
        logic [WIDTH:0] predicted_pc;
        logic [INDEX:0] ghr_index;
        logic [1:0]     pht_state;
        logic           redirect;
        logic           resolved;
        logic           taken;
        logic [WIDTH:0] target;
    } cfc_entry_t;

    // A taken branch that fetch also redirected is still wrong when the
    // real target differs from the BTB guess.
    function automatic logic is_mispredict(input cfc_entry_t e);
        return (e.taken != e.redirect) |
               (e.taken & e.redirect & (e.target != e.predicted_pc));
    endfunction

endpackage

// File: rtl/control_flow_commit_pht.sv
// -----------------------------------------------------------------------------
// pht_counter_update
// Combinational 2-bit saturating counter update for the gshare PHT entry.
//   taken      : resolved branch direction
//   state      : counter value read at fetch
//   next_state : counter value to write back (saturates at 2'b00 / 2'b11)
// -----------------------------------------------------------------------------
module pht_counter_update (
    input  logic       taken,
    input  logic [1:0] state,
    output logic [1:0] next_state
);

    // Saturating increment on taken, saturating decrement on not-taken
    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != 2'b11) begin
                next_state = state + 2'b01;
            end else begin
                next_state = 2'b11;
            end
        end else begin
            if (state != 2'b00) begin
                next_state = state - 2'b01;
            end else begin
                next_state = 2'b00;
            end
        end
    end

endmodule

// File: rtl/control_flow_commit.sv
// -----------------------------------------------------------------------------
// control_flow_commit
// In-order commit queue for branches/JALs. Fetch allocates an entry at the
// tail, execute resolves entries out of order by tag, and the oldest entry
// retires once resolved and the ROB allows it, producing the registered
// writeCommit fields for fetch. A mispredicting commit flushes the queue.
//   clk, globalReset                  : clock, async active-high reset
//   alloc*                            : fetch-side allocation request
//   allocTag, full                    : slot for this allocation, queue full
//   resolve*                          : execute-side outcome for a tag
//   commitEnable                      : ROB permits oldest branch to retire
//   validCommit, targetAddress, oldPC,
//   controlFlow, previousIndex,
//   commitBranch                      : registered commit bus to fetch
// -----------------------------------------------------------------------------
module control_flow_commit
    import control_flow_commit_pkg::*;
(
    input  logic             clk,
    input  logic             globalReset,
    input  logic             allocValid,
    input  logic [WIDTH:0]   allocPC,
    input  logic [WIDTH:0]   allocPredictedPC,
    input  logic [INDEX:0]   allocGHRIndex,
    input  logic [1:0]       allocPHTState,
    input  logic             allocRedirect,
    output logic [PTR_W-1:0] allocTag,
    output logic             full,
    input  logic             resolveValid,
    input  logic [PTR_W-1:0] resolveTag,
    input  logic             resolveTaken,
    input  logic [WIDTH:0]   resolveTarget,
    input  logic             commitEnable,
    output logic             validCommit,
    output logic [WIDTH:0]   targetAddress,
    output logic [WIDTH:0]   oldPC,
    output logic [4:0]       controlFlow,
    output logic [INDEX:0]   previousIndex,
    output logic             commitBranch
);

    localparam logic [WIDTH:0]   PC_STEP    = {{(WIDTH-2){1'b0}}, 3'd4};
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);

    cfc_entry_t       entries_q [DEPTH];
    cfc_entry_t       entries_d [DEPTH];
    logic [DEPTH-1:0] occupied_q, occupied_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             valid_commit_q, valid_commit_d;
    logic [WIDTH:0]   target_address_q, target_address_d;
    logic [WIDTH:0]   old_pc_q, old_pc_d;
    logic [4:0]       control_flow_q, control_flow_d;
    logic [INDEX:0]   previous_index_q, previous_index_d;
    logic             commit_branch_q, commit_branch_d;

    cfc_entry_t       head_entry;
    logic             commit_fire, mispredict, flush;
    logic             alloc_fire, resolve_fire;
    logic [1:0]       pht_next;

    assign head_entry = entries_q[head_q];
    assign full       = (count_q == COUNT_FULL);
    assign allocTag   = tail_q;

    // Retirement uses the registered resolved bit, so a resolve into the head
    // can only retire on the following edge.
    assign commit_fire  = occupied_q[head_q] & head_entry.resolved & commitEnable;
    assign mispredict   = is_mispredict(head_entry);
    assign flush        = commit_fire & mispredict;
    assign alloc_fire   = allocValid & ~full & ~flush;
    assign resolve_fire = resolveValid & occupied_q[resolveTag] &
                          ~entries_q[resolveTag].resolved & ~flush;

    pht_counter_update u_pht (
        .taken      (head_entry.taken),
        .state      (head_entry.pht_state),
        .next_state (pht_next)
    );

    // Queue bookkeeping: flush, resolve, retire and allocate
    always_comb begin
        entries_d  = entries_q;
        occupied_d = occupied_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            occupied_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (resolve_fire) begin
                entries_d[resolveTag].resolved = 1'b1;
                entries_d[resolveTag].taken    = resolveTaken;
                entries_d[resolveTag].target   = resolveTarget;
            end else begin
                entries_d[resolveTag] = entries_q[resolveTag];
            end
            if (commit_fire) begin
                occupied_d[head_q] = 1'b0;
                head_d             = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            // Tail slot is free whenever allocation is allowed, so it never
            // collides with the head being retired or the tag being resolved.
            if (alloc_fire) begin
                entries_d[tail_q].pc           = allocPC;
                entries_d[tail_q].predicted_pc = allocPredictedPC;
                entries_d[tail_q].ghr_index    = allocGHRIndex;
                entries_d[tail_q].pht_state    = allocPHTState;
                entries_d[tail_q].redirect     = allocRedirect;
                entries_d[tail_q].resolved     = 1'b0;
                entries_d[tail_q].taken        = 1'b0;
                entries_d[tail_q].target       = '0;
                occupied_d[tail_q]             = 1'b1;
                tail_d                         = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Commit bus: pulse validCommit and load fields on retirement, else hold
    always_comb begin
        valid_commit_d   = commit_fire;
        target_address_d = target_address_q;
        old_pc_d         = old_pc_q;
        control_flow_d   = control_flow_q;
        previous_index_d = previous_index_q;
        commit_branch_d  = commit_branch_q;
        if (commit_fire) begin
            target_address_d = head_entry.taken ? head_entry.target
                                                : head_entry.pc + PC_STEP;
            old_pc_d         = head_entry.pc;
            previous_index_d = head_entry.ghr_index;
            commit_branch_d  = 1'b1;
            control_flow_d                          = 5'b00000;
            control_flow_d[CF_MISPREDICT]           = mispredict;
            control_flow_d[CF_TAKEN]                = head_entry.taken;
            control_flow_d[CF_BTB_WRITE]            = head_entry.taken;
            control_flow_d[CF_PHT_MSB:CF_PHT_LSB]   = pht_next;
        end else begin
            commit_branch_d = commit_branch_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occupied_q       <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_commit_q   <= 1'b0;
            target_address_q <= '0;
            old_pc_q         <= '0;
            control_flow_q   <= 5'b00000;
            previous_index_q <= '0;
            commit_branch_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occupied_q       <= occupied_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            valid_commit_q   <= valid_commit_d;
            target_address_q <= target_address_d;
            old_pc_q         <= old_pc_d;
            control_flow_q   <= control_flow_d;
            previous_index_q <= previous_index_d;
            commit_branch_q  <= commit_branch_d;
        end
    end

    assign validCommit   = valid_commit_q;
    assign targetAddress = target_address_q;
    assign oldPC         = old_pc_q;
    assign controlFlow   = control_flow_q;
    assign previousIndex = previous_index_q;
    assign commitBranch  = commit_branch_q;

endmodule
